// File: rtl/droic_serial_rx.sv
// droic_serial_rx: recovers ADC pixel words from the CPLD serial readout link.
// Frame format: HDR_LEN ones, DATA_BITS data bits (MSB first), TRL_LEN zeros.
// All inputs are asynchronous to OSC_in and are resynchronised before use.
module droic_serial_rx #(
    parameter int HDR_LEN   = 9,
    parameter int DATA_BITS = 10,
    parameter int TRL_LEN   = 3,
    parameter int ROWS      = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                 OSC_in,
    input  logic                 Rst_n,
    input  logic                 SClk,
    input  logic                 SData,
    input  logic                 SSmpl,
    output logic [DATA_BITS-1:0] WordData,
    output logic                 WordValid,
    output logic [1:0]           RowIdx,
    output logic                 FrameErr,
    output logic [7:0]           ErrCount
);

    localparam int CW = $clog2(DATA_BITS + TRL_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0]    HDR_LAST  = 4'(HDR_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] TRL_LAST  = CW'(TRL_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [1:0]    ROW_LAST  = 2'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TRL  = 2'd2
    } state_t;

    // Synchronizer flops (SData needs no third stage: it is sampled at s2)
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic sdata_s1_q, sdata_s2_q;
    logic ssmpl_s1_q, ssmpl_s2_q, ssmpl_s3_q;

    // Frame state
    state_t                 state_q;
    logic [3:0]             ones_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   trl_bad_q;
    logic [TW-1:0]          idle_cnt_q, idle_cnt_d;
    logic [1:0]             row_cnt_q, row_cnt_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    // Registered outputs
    logic [DATA_BITS-1:0]   word_data_q;
    logic                   word_valid_q;
    logic [1:0]             row_idx_q;
    logic                   frame_err_q;

    logic sclk_rise;
    logic smpl_rise;
    logic bit_in;
    logic in_frame;
    logic timeout_hit;
    logic abort;

    // SData shares the SClk depth so the captured bit is the one present at the pin edge
    assign sclk_rise   = sclk_s2_q & ~sclk_s3_q;
    assign smpl_rise   = ssmpl_s2_q & ~ssmpl_s3_q;
    assign bit_in      = sdata_s2_q;
    assign in_frame    = (state_q != ST_IDLE);
    // An edge in the same cycle beats the timeout
    assign timeout_hit = in_frame & ~sclk_rise & (idle_cnt_q == TO_LAST);
    assign abort       = in_frame & (smpl_rise | timeout_hit);

    // Two/three-stage input synchronizers for the asynchronous link lines
    always_ff @(posedge OSC_in) begin
        if (!Rst_n) begin
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
            sdata_s1_q <= 1'b0;
            sdata_s2_q <= 1'b0;
            ssmpl_s1_q <= 1'b0;
            ssmpl_s2_q <= 1'b0;
            ssmpl_s3_q <= 1'b0;
        end else begin
            sclk_s1_q  <= SClk;
            sclk_s2_q  <= sclk_s1_q;
            sclk_s3_q  <= sclk_s2_q;
            sdata_s1_q <= SData;
            sdata_s2_q <= sdata_s1_q;
            ssmpl_s1_q <= SSmpl;
            ssmpl_s2_q <= ssmpl_s1_q;
            ssmpl_s3_q <= ssmpl_s2_q;
        end
    end

    // Next values for the idle watchdog, row counter and saturating error counter
    always_comb begin
        idle_cnt_d = idle_cnt_q + TW'(1);
        if (!in_frame || sclk_rise || abort) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
        end

        row_cnt_d = row_cnt_q + 2'd1;
        if (row_cnt_q >= ROW_LAST) begin
            row_cnt_d = 2'd0;
        end else begin
            row_cnt_d = row_cnt_q + 2'd1;
        end

        err_cnt_d = err_cnt_q;
        if (err_cnt_q == 8'hFF) begin
            err_cnt_d = err_cnt_q;
        end else begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Frame FSM: header hunt, data shift, trailer check, abort handling, outputs
    always_ff @(posedge OSC_in) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            ones_q       <= 4'd0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            trl_bad_q    <= 1'b0;
            idle_cnt_q   <= '0;
            row_cnt_q    <= 2'd0;
            err_cnt_q    <= 8'd0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            row_idx_q    <= 2'd0;
            frame_err_q  <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            idle_cnt_q   <= idle_cnt_d;

            if (abort) begin
                // Resync flag or stalled link: drop the frame, hunt for a new header
                state_q     <= ST_IDLE;
                ones_q      <= 4'd0;
                bit_cnt_q   <= '0;
                shreg_q     <= '0;
                trl_bad_q   <= 1'b0;
                frame_err_q <= 1'b1;
                err_cnt_q   <= err_cnt_d;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (smpl_rise) begin
                            ones_q <= 4'd0;
                        end else if (sclk_rise) begin
                            if (bit_in) begin
                                if (ones_q == HDR_LAST) begin
                                    ones_q    <= 4'd0;
                                    bit_cnt_q <= '0;
                                    shreg_q   <= '0;
                                    state_q   <= ST_DATA;
                                end else begin
                                    ones_q <= ones_q + 4'd1;
                                end
                            end else begin
                                ones_q <= 4'd0;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (sclk_rise) begin
                            shreg_q <= {shreg_q[DATA_BITS-2:0], bit_in};
                            if (bit_cnt_q == DATA_LAST) begin
                                bit_cnt_q <= '0;
                                trl_bad_q <= 1'b0;
                                state_q   <= ST_TRL;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CW'(1);
                            end
                        end
                    end

                    ST_TRL: begin
                        if (sclk_rise) begin
                            if (bit_cnt_q == TRL_LAST) begin
                                state_q   <= ST_IDLE;
                                bit_cnt_q <= '0;
                                trl_bad_q <= 1'b0;
                                shreg_q   <= '0;
                                if (!(trl_bad_q | bit_in)) begin
                                    word_data_q  <= shreg_q;
                                    word_valid_q <= 1'b1;
                                    row_idx_q    <= row_cnt_q;
                                    row_cnt_q    <= row_cnt_d;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    err_cnt_q   <= err_cnt_d;
                                end
                            end else begin
                                trl_bad_q <= trl_bad_q | bit_in;
                                bit_cnt_q <= bit_cnt_q + CW'(1);
                            end
                        end
                    end

                    default: begin
                        state_q   <= ST_IDLE;
                        ones_q    <= 4'd0;
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                        trl_bad_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign WordData  = word_data_q;
    assign WordValid = word_valid_q;
    assign RowIdx    = row_idx_q;
    assign FrameErr  = frame_err_q;
    assign ErrCount  = err_cnt_q;

endmodule

// File: tb/tb_droic_serial_rx.sv
// Self-checking bench for droic_serial_rx: a table of whole frames plus
// hand-written sequences for timeout, resync, simultaneous abort and reset.
module tb_droic_serial_rx;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       sdata;
    logic       ssmpl;
    logic [9:0] word_data;
    logic       word_valid;
    logic [1:0] row_idx;
    logic       frame_err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_both  = 0;
    logic [9:0] last_data = 10'd0;
    logic [1:0] last_row  = 2'd0;

    droic_serial_rx dut (
        .OSC_in    (clk),
        .Rst_n     (rst_n),
        .SClk      (sclk),
        .SData     (sdata),
        .SSmpl     (ssmpl),
        .WordData  (word_data),
        .WordValid (word_valid),
        .RowIdx    (row_idx),
        .FrameErr  (frame_err),
        .ErrCount  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (word_valid) begin
            n_valid   <= n_valid + 1;
            last_data <= word_data;
            last_row  <= row_idx;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (word_valid && frame_err) n_both <= n_both + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input logic smpl);
        sdata = b;
        tick(3);
        sclk  = 1'b1;
        ssmpl = smpl;
        tick(3);
        sclk  = 1'b0;
        ssmpl = 1'b0;
    endtask

    task automatic send_header();
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [9:0] d, input logic [2:0] t, input logic smpl_last);
        send_header();
        for (int i = 9; i >= 0; i--) send_bit(d[i], 1'b0);
        send_bit(t[2], 1'b0);
        send_bit(t[1], 1'b0);
        send_bit(t[0], smpl_last);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, " rst WordData"},  {22'd0, word_data}, 32'd0);
        check({tag, " rst WordValid"}, {31'd0, word_valid}, 32'd0);
        check({tag, " rst RowIdx"},    {30'd0, row_idx},   32'd0);
        check({tag, " rst FrameErr"},  {31'd0, frame_err}, 32'd0);
        check({tag, " rst ErrCount"},  {24'd0, err_count}, 32'd0);
        tick(1);
    endtask

    task automatic check_frame(input string tag, input int nv0, input int nf0,
                               input bit ok, input logic [9:0] d,
                               input logic [1:0] row, input logic [7:0] ec);
        check({tag, " valid_pulses"}, n_valid - nv0, ok ? 32'd1 : 32'd0);
        check({tag, " ferr_pulses"},  n_ferr - nf0,  ok ? 32'd0 : 32'd1);
        if (ok) begin
            check({tag, " WordData"}, {22'd0, last_data}, {22'd0, d});
            check({tag, " RowIdx"},   {30'd0, last_row},  {30'd0, row});
        end
        check({tag, " ErrCount"}, {24'd0, err_count}, {24'd0, ec});
    endtask

    typedef struct {
        bit         rst;
        logic [9:0] data;
        logic [2:0] trl;
        bit         ok;
        logic [1:0] row;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int nv0;
        int nf0;

        vecs[0]  = '{1'b1, 10'h2B5, 3'b000, 1'b1, 2'd0, 8'd0};  // nominal
        vecs[1]  = '{1'b1, 10'h001, 3'b000, 1'b1, 2'd0, 8'd0};  // row wrap start
        vecs[2]  = '{1'b0, 10'h002, 3'b000, 1'b1, 2'd1, 8'd0};
        vecs[3]  = '{1'b0, 10'h003, 3'b000, 1'b1, 2'd2, 8'd0};
        vecs[4]  = '{1'b0, 10'h004, 3'b000, 1'b1, 2'd0, 8'd0};  // wrapped
        vecs[5]  = '{1'b0, 10'h155, 3'b010, 1'b0, 2'd0, 8'd1};  // bad trailer
        vecs[6]  = '{1'b0, 10'h3FF, 3'b000, 1'b1, 2'd1, 8'd1};
        vecs[7]  = '{1'b0, 10'h000, 3'b001, 1'b0, 2'd0, 8'd2};  // last trailer bit bad
        vecs[8]  = '{1'b0, 10'h3FF, 3'b100, 1'b0, 2'd0, 8'd3};  // first trailer bit bad
        vecs[9]  = '{1'b0, 10'h200, 3'b000, 1'b1, 2'd2, 8'd3};
        vecs[10] = '{1'b0, 10'h3FE, 3'b000, 1'b1, 2'd0, 8'd3};

        rst_n = 1'b0;
        sclk  = 1'b0;
        sdata = 1'b0;
        ssmpl = 1'b0;
        tick(3);

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].rst) begin
                do_reset(2);
                check_reset_outputs($sformatf("vec%0d", v));
            end
            nv0 = n_valid;
            nf0 = n_ferr;
            send_frame(vecs[v].data, vecs[v].trl, 1'b0);
            tick(6);
            check_frame($sformatf("vec%0d", v), nv0, nf0, vecs[v].ok,
                        vecs[v].data, vecs[v].row, vecs[v].ec);
        end

        // Timeout: link stalls after the 5th data bit
        nv0 = n_valid;
        nf0 = n_ferr;
        send_header();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        tick(200);
        check("timeout early_ferr", n_ferr - nf0, 32'd0);
        tick(100);
        check_frame("timeout", nv0, nf0, 1'b0, 10'h000, 2'd0, 8'd4);
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(10'h0F0, 3'b000, 1'b0);
        tick(6);
        check_frame("after_timeout", nv0, nf0, 1'b1, 10'h0F0, 2'd1, 8'd4);

        // Mid-frame resync via SSmpl during DATA
        nv0 = n_valid;
        nf0 = n_ferr;
        send_header();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        ssmpl = 1'b1;
        tick(3);
        ssmpl = 1'b0;
        tick(6);
        check_frame("resync", nv0, nf0, 1'b0, 10'h000, 2'd0, 8'd5);
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(10'h0AA, 3'b000, 1'b0);
        tick(6);
        check_frame("after_resync", nv0, nf0, 1'b1, 10'h0AA, 2'd2, 8'd5);

        // SSmpl rise coincident with the final trailer edge: abort wins
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(10'h123, 3'b000, 1'b1);
        tick(6);
        check_frame("smpl_vs_trl", nv0, nf0, 1'b0, 10'h000, 2'd0, 8'd6);

        // Reset pulse during the trailer
        send_header();
        for (int i = 9; i >= 0; i--) send_bit(((10'h2B5 >> i) & 10'h001) != 10'h000, 1'b0);
        send_bit(1'b0, 1'b0);
        do_reset(1);
        check_reset_outputs("midtrl");
        nv0 = n_valid;
        nf0 = n_ferr;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        tick(6);
        check("midtrl valid_pulses", n_valid - nv0, 32'd0);
        check("midtrl ferr_pulses",  n_ferr - nf0,  32'd0);
        check("midtrl ErrCount",     {24'd0, err_count}, 32'd0);
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(10'h2B5, 3'b000, 1'b0);
        tick(6);
        check_frame("after_reset", nv0, nf0, 1'b1, 10'h2B5, 2'd0, 8'd0);

        check("valid_and_ferr_overlap", n_both, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
